pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register, the successor to the fixed-field decode/execute register.
- Carries a valid bit, a packed control word, NUM_DATA datapath words of WIDTH bits and a register-tag field.
- Adds stall (hold), flush (bubble injection) and clear-on-invalid behaviour.
- Instantiated at every stage boundary (F/D, D/E, E/M, M/W), so hazard logic can freeze or squash any stage.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_sat_counter.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage registers.
// The D/E control word layout defines the default control width.
package pipe_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 5;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       ALUsrc;
    logic [1:0] resultSrc;
    logic [2:0] ALUctrl;
    logic [2:0] branch;
  } ctrl_de_t;

  localparam int CTRL_DE_W = $bits(ctrl_de_t);

  typedef enum logic [1:0] {
    STG_FD = 2'd0,
    STG_DE = 2'd1,
    STG_EM = 2'd2,
    STG_MW = 2'd3
  } stage_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous active-low reset and clear.
// Clear takes priority over increment; the count sticks at all-ones.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, flush and clear-on-invalid.
// Define PIPE_STAGE_PERF_CNT_EN to add saturating stall/flush/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH              = DATA_WIDTH,
  parameter int NUM_DATA           = 5,
  parameter int CTRL_W             = CTRL_DE_W,
  parameter int TAG_W              = TAG_WIDTH,
  parameter int ZERO_DATA_ON_FLUSH = 0
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  parameter int CNT_W              = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_D,
  input  logic [CTRL_W-1:0]         ctrl_D,
  input  logic [TAG_W-1:0]          tag_D,
  input  logic [NUM_DATA*WIDTH-1:0] data_D,
  output logic                      valid_E,
  output logic [CTRL_W-1:0]         ctrl_E,
  output logic [TAG_W-1:0]          tag_E,
  output logic [NUM_DATA*WIDTH-1:0] data_E
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
`endif
);

  logic                      valid_q, valid_d;
  logic [CTRL_W-1:0]         ctrl_q,  ctrl_d;
  logic [TAG_W-1:0]          tag_q,   tag_d;
  logic [NUM_DATA*WIDTH-1:0] data_q,  data_d;

  // Next-state selection in priority order flush > stall > load.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (ZERO_DATA_ON_FLUSH != 0) begin
        tag_d  = '0;
        data_d = '0;
      end else begin
        tag_d  = tag_q;
        data_d = data_q;
      end
    end else if (stall) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end else begin
      // Invalid entries never carry side-effecting control.
      valid_d = valid_D;
      ctrl_d  = valid_D ? ctrl_D : '0;
      tag_d   = tag_D;
      data_d  = data_D;
    end
  end

  // Stage state registers; reset overrides flush and stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid_E = valid_q;
  assign ctrl_E  = ctrl_q;
  assign tag_E   = tag_q;
  assign data_E  = data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic stall_inc_s;
  logic flush_inc_s;
  logic bubble_inc_s;

  assign stall_inc_s  = stall & ~flush;
  assign flush_inc_s  = flush;
  assign bubble_inc_s = ~stall & ~flush & ~valid_D;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (flush_inc_s),
    .count (flush_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (bubble_inc_s),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (flush holds / flush zeroes)
// share the same stimulus; expectations come from an independent behavioural model.
module tb_pipe_stage_reg;

  localparam int DW = 5 * 32;

  typedef struct packed {
    logic          v;
    logic [11:0]   c;
    logic [4:0]    t;
    logic [DW-1:0] d;
  } stage_t;

  typedef struct packed {
    stage_t     s0;
    stage_t     s1;
    logic [3:0] sc;
    logic [3:0] fc;
    logic [3:0] bc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, stall, flush, valid_D;
  logic [11:0]   ctrl_D;
  logic [4:0]    tag_D;
  logic [DW-1:0] data_D;

  logic          valid_E0, valid_E1;
  logic [11:0]   ctrl_E0, ctrl_E1;
  logic [4:0]    tag_E0, tag_E1;
  logic [DW-1:0] data_E0, data_E1;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic       cnt_clr;
  logic [3:0] sc0, fc0, bc0, sc1, fc1, bc1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  stage_t m0, m1;
  logic [3:0] msc, mfc, mbc;
  exp_t sbq[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.ZERO_DATA_ON_FLUSH(0)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_D(valid_D), .ctrl_D(ctrl_D), .tag_D(tag_D), .data_D(data_D),
    .valid_E(valid_E0), .ctrl_E(ctrl_E0), .tag_E(tag_E0), .data_E(data_E0)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .stall_cnt(sc0), .flush_cnt(fc0), .bubble_cnt(bc0)
`endif
  );

  pipe_stage_reg #(.ZERO_DATA_ON_FLUSH(1)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_D(valid_D), .ctrl_D(ctrl_D), .tag_D(tag_D), .data_D(data_D),
    .valid_E(valid_E1), .ctrl_E(ctrl_E1), .tag_E(tag_E1), .data_E(data_E1)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .stall_cnt(sc1), .flush_cnt(fc1), .bubble_cnt(bc1)
`endif
  );

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stage_t model_next(stage_t cur, bit zero_on_flush);
    stage_t n = cur;
    if (!rst) begin
      n = '0;
    end else if (flush) begin
      n.v = 1'b0;
      n.c = 12'h000;
      if (zero_on_flush) begin
        n.t = 5'd0;
        n.d = '0;
      end
    end else if (!stall) begin
      n.v = valid_D;
      n.c = valid_D ? ctrl_D : 12'h000;
      n.t = tag_D;
      n.d = data_D;
    end
    return n;
  endfunction

  function automatic logic [3:0] cnt_next(logic [3:0] c, bit inc, bit clr);
    if (!rst || clr) return 4'h0;
    if (inc && c != 4'hF) return c + 4'h1;
    return c;
  endfunction

  task automatic step();
    exp_t e;
    bit clr_now = 1'b0;
`ifdef PIPE_STAGE_PERF_CNT_EN
    clr_now = cnt_clr;
`endif
    e.s0 = model_next(m0, 1'b0);
    e.s1 = model_next(m1, 1'b1);
    e.sc = cnt_next(msc, stall && !flush, clr_now);
    e.fc = cnt_next(mfc, flush, clr_now);
    e.bc = cnt_next(mbc, !stall && !flush && !valid_D, clr_now);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check_val("sb_empty", 160'd1, 160'd0);
    end else begin
      e = sbq.pop_front();
      check_val("valid0", {159'd0, valid_E0}, {159'd0, e.s0.v});
      check_val("ctrl0",  {148'd0, ctrl_E0},  {148'd0, e.s0.c});
      check_val("tag0",   {155'd0, tag_E0},   {155'd0, e.s0.t});
      check_val("data0",  data_E0,            e.s0.d);
      check_val("valid1", {159'd0, valid_E1}, {159'd0, e.s1.v});
      check_val("ctrl1",  {148'd0, ctrl_E1},  {148'd0, e.s1.c});
      check_val("tag1",   {155'd0, tag_E1},   {155'd0, e.s1.t});
      check_val("data1",  data_E1,            e.s1.d);
      if (!valid_E0) check_val("inv_ctrl0", {148'd0, ctrl_E0}, 160'd0);
      if (!valid_E1) check_val("inv_ctrl1", {148'd0, ctrl_E1}, 160'd0);
`ifdef PIPE_STAGE_PERF_CNT_EN
      check_val("stall_cnt0",  {156'd0, sc0}, {156'd0, e.sc});
      check_val("flush_cnt0",  {156'd0, fc0}, {156'd0, e.fc});
      check_val("bubble_cnt0", {156'd0, bc0}, {156'd0, e.bc});
      check_val("stall_cnt1",  {156'd0, sc1}, {156'd0, e.sc});
      check_val("flush_cnt1",  {156'd0, fc1}, {156'd0, e.fc});
      check_val("bubble_cnt1", {156'd0, bc1}, {156'd0, e.bc});
`endif
      m0  = e.s0;
      m1  = e.s1;
      msc = e.sc;
      mfc = e.fc;
      mbc = e.bc;
    end
  endtask

  initial begin
    m0 = '0; m1 = '0; msc = 4'h0; mfc = 4'h0; mbc = 4'h0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_D = 1'b1;
    ctrl_D = 12'hA5C; tag_D = 5'd7;
    data_D = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
`ifdef PIPE_STAGE_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    // reset held for two cycles
    step();
    step();
    check_val("rst_valid", {159'd0, valid_E0}, 160'd0);
    check_val("rst_data",  data_E0, 160'd0);

    // release and load
    rst = 1'b1;
    step();
    check_val("tp_ctrl",  {148'd0, ctrl_E0}, {148'd0, 12'hA5C});
    check_val("tp_tag",   {155'd0, tag_E0},  160'd7);
    check_val("tp_word0", {128'd0, data_E0[31:0]}, {128'd0, 32'hDEADBEEF});

    // stall for three cycles while upstream changes
    stall = 1'b1;
    data_D[31:0] = 32'h12345678;
    ctrl_D = 12'h3C3;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_word0", {128'd0, data_E0[31:0]}, {128'd0, 32'hDEADBEEF});
    end
`ifdef PIPE_STAGE_PERF_CNT_EN
    check_val("tp_stall_cnt", {156'd0, sc0}, 160'd3);
`endif
    stall = 1'b0;
    step();
    check_val("load_word0", {128'd0, data_E0[31:0]}, {128'd0, 32'h12345678});

    // flush together with stall
    flush = 1'b1; stall = 1'b1;
    step();
    check_val("fl_valid",  {159'd0, valid_E0}, 160'd0);
    check_val("fl_hold",   {128'd0, data_E0[31:0]}, {128'd0, 32'h12345678});
    check_val("fl_zero",   data_E1, 160'd0);
    flush = 1'b0; stall = 1'b0;

    // clear-on-invalid
    valid_D = 1'b0; ctrl_D = 12'hFFF; tag_D = 5'd9;
    step();
    check_val("coi_ctrl", {148'd0, ctrl_E0}, 160'd0);
    check_val("coi_tag",  {155'd0, tag_E0}, 160'd9);

    // reset while stalled
    valid_D = 1'b1; ctrl_D = 12'h5A1;
    step();
    stall = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_val("rst_stall_v", {159'd0, valid_E0}, 160'd0);
    check_val("rst_stall_d", data_E0, 160'd0);
    rst = 1'b1; stall = 1'b0;

`ifdef PIPE_STAGE_PERF_CNT_EN
    // counter saturation then clear
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_val("sat_stall", {156'd0, sc0}, 160'd15);
    stall = 1'b0; cnt_clr = 1'b1;
    step();
    check_val("clr_stall", {156'd0, sc0}, 160'd0);
    cnt_clr = 1'b0;
`endif

    // random mix
    for (int i = 0; i < 60; i++) begin
      rst     = ($urandom_range(0, 15) != 0);
      stall   = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 4) == 0);
      valid_D = $urandom_range(0, 1) != 0;
      ctrl_D  = 12'($urandom);
      tag_D   = 5'($urandom);
      data_D  = {$urandom, $urandom, $urandom, $urandom, $urandom};
`ifdef PIPE_STAGE_PERF_CNT_EN
      cnt_clr = ($urandom_range(0, 19) == 0);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
